push_reg_bank: RTL and testbench

Byte-stream register bank fed by the push interface of the RS232 receiver. It parses framed write commands (header, little-endian payload, XOR checksum) and updates one of CHANNELS output registers of WIDTH bits. It generalises the single 8-bit LED latch to multiple, wider channels, and adds checksum validation, inter-byte timeout resynchronisation and an error counter. It sits between `rs232_to_push` and application logic: LEDs, PWM setpoints, control words.

---
 rtl/push_reg_bank.sv | 154 +++++++++++++++
 tb/tb_push_reg_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/push_reg_bank.sv
// rtl/push_reg_bank.sv - framed byte-stream writer for a bank of output registers
//
// Parses frames {header 0xA<ch>, payload P0..P(NBYTES-1) little-endian, XOR checksum}
// arriving one byte per push strobe and writes the payload into register <ch>.
//
// Ports:
//   clock_i   system clock, all state changes on the rising edge
//   resetn_i  asynchronous active-low reset
//   data_i    received byte, valid while push_i is high
//   push_i    one-cycle byte strobe
//   full_o    back-pressure, tied low (a byte is accepted every cycle)
//   regs_o    register c at bits [c*WIDTH +: WIDTH]
//   update_o  one-cycle strobe per channel, high the cycle after a write
//   errors_o  saturating count of rejected or timed-out frames
//   busy_o    high while a frame is being received
module push_reg_bank #(
    parameter int               CHANNELS    = 4,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               INVERT      = 0,
    parameter int               TIMEOUT     = 133000
) (
    input  logic                      clock_i,
    input  logic                      resetn_i,
    input  logic [7:0]                data_i,
    input  logic                      push_i,
    output logic                      full_o,
    output logic [CHANNELS*WIDTH-1:0] regs_o,
    output logic [CHANNELS-1:0]       update_o,
    output logic [7:0]                errors_o,
    output logic                      busy_o
);

    localparam int NBYTES = (WIDTH + 7) / 8;
    localparam int TW     = $clog2(TIMEOUT);

    localparam logic [1:0]       BCNT_LAST = 2'(NBYTES - 1);
    localparam logic [TW-1:0]    TCNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] INV_MASK  = {WIDTH{1'(INVERT)}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                    state_q;
    logic [3:0]                chan_q;
    logic [WIDTH-1:0]          payload_q;
    logic [7:0]                csum_q;
    logic [1:0]                bcnt_q;
    logic [TW-1:0]             tcnt_q;
    logic [CHANNELS*WIDTH-1:0] regs_q;
    logic [CHANNELS-1:0]       update_q;
    logic                      err_pend_q;
    logic [7:0]                errors_q;

    logic                      chan_ok;
    logic [WIDTH-1:0]          store_val;
    logic                      timed_out;

    // Zero-extended to 5 bits so CHANNELS=16 compares correctly.
    assign chan_ok   = ({1'b0, chan_q} < 5'(CHANNELS));
    assign store_val = payload_q ^ INV_MASK;
    assign timed_out = (tcnt_q == TCNT_LAST);

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            chan_q     <= '0;
            payload_q  <= '0;
            csum_q     <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
            regs_q     <= {CHANNELS{RESET_VALUE}};
            update_q   <= '0;
            err_pend_q <= 1'b0;
            errors_q   <= '0;
        end else begin
            update_q   <= '0;
            err_pend_q <= 1'b0;

            // Rejections are flagged on the deciding edge and counted one edge later.
            if (err_pend_q && errors_q != 8'hFF) begin
                errors_q <= errors_q + 8'd1;
            end

            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (push_i && data_i[7:4] == 4'hA) begin
                        chan_q    <= data_i[3:0];
                        payload_q <= '0;
                        csum_q    <= data_i;
                        bcnt_q    <= '0;
                        state_q   <= DATA;
                    end
                end

                DATA: begin
                    if (push_i) begin
                        // Bits beyond WIDTH fall off the shift; they still feed the checksum.
                        payload_q <= payload_q | (WIDTH'(data_i) << {bcnt_q, 3'b000});
                        csum_q    <= csum_q ^ data_i;
                        tcnt_q    <= '0;
                        if (bcnt_q == BCNT_LAST) begin
                            state_q <= CHECK;
                        end else begin
                            bcnt_q <= bcnt_q + 2'd1;
                        end
                    end else if (timed_out) begin
                        err_pend_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end

                CHECK: begin
                    if (push_i) begin
                        tcnt_q  <= '0;
                        state_q <= IDLE;
                        if (data_i == csum_q && chan_ok) begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                if (chan_q == 4'(c)) begin
                                    regs_q[c*WIDTH +: WIDTH] <= store_val;
                                    update_q[c]              <= 1'b1;
                                end
                            end
                        end else begin
                            err_pend_q <= 1'b1;
                        end
                    end else if (timed_out) begin
                        err_pend_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign full_o   = 1'b0;
    assign regs_o   = regs_q;
    assign update_o = update_q;
    assign errors_o = errors_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_push_reg_bank.sv
// tb/tb_push_reg_bank.sv - directed bench for push_reg_bank
module tb_push_reg_bank;

    logic        clk;
    logic        resetn;
    logic [7:0]  data_a, data_b;
    logic        push_a, push_b;
    logic        full_a, full_b;
    logic [47:0] regs_a;
    logic [31:0] regs_b;
    logic [3:0]  update_a, update_b;
    logic [7:0]  errors_a, errors_b;
    logic        busy_a, busy_b;

    int n_pass  = 0;
    int n_total = 0;

    push_reg_bank #(
        .CHANNELS(4), .WIDTH(12), .RESET_VALUE(12'h000), .INVERT(0), .TIMEOUT(16)
    ) u_a (
        .clock_i(clk), .resetn_i(resetn), .data_i(data_a), .push_i(push_a),
        .full_o(full_a), .regs_o(regs_a), .update_o(update_a),
        .errors_o(errors_a), .busy_o(busy_a)
    );

    push_reg_bank #(
        .CHANNELS(4), .WIDTH(8), .RESET_VALUE(8'h5A), .INVERT(1), .TIMEOUT(16)
    ) u_b (
        .clock_i(clk), .resetn_i(resetn), .data_i(data_b), .push_i(push_b),
        .full_o(full_b), .regs_o(regs_b), .update_o(update_b),
        .errors_o(errors_b), .busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input logic [7:0] b);
        data_a = b;
        push_a = 1'b1;
        @(posedge clk);
        #1;
        push_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        data_b = b;
        push_b = 1'b1;
        @(posedge clk);
        #1;
        push_b = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        data_a = 8'h00; push_a = 1'b0;
        data_b = 8'h00; push_b = 1'b0;
        idle(3);
        check("rst_regs_a",   regs_a,   48'h0);
        check("rst_regs_b",   regs_b,   32'h5A5A5A5A);
        check("rst_update_a", update_a, 4'b0000);
        check("rst_errors_a", errors_a, 8'd0);
        check("rst_busy_a",   busy_a,   1'b0);
        check("rst_full_a",   full_a,   1'b0);
        resetn = 1'b1;
        idle(1);

        // valid frame to channel 2
        send_a(8'hA2);
        check("hdr_busy", busy_a, 1'b1);
        send_a(8'h34); send_a(8'h0B); send_a(8'h9D);
        check("wr2_regs",   regs_a,   48'h000_B34_000_000);
        check("wr2_update", update_a, 4'b0100);
        check("wr2_busy",   busy_a,   1'b0);
        idle(1);
        check("wr2_update_off", update_a, 4'b0000);
        check("wr2_errors",     errors_a, 8'd0);

        // bad checksum, then a valid frame to channel 0 back-to-back
        send_a(8'hA2); send_a(8'h34); send_a(8'h0B); send_a(8'h9C);
        check("badsum_regs",   regs_a,   48'h000_B34_000_000);
        check("badsum_update", update_a, 4'b0000);
        send_a(8'hA0);
        check("badsum_errors", errors_a, 8'd1);
        send_a(8'hFF); send_a(8'h0F); send_a(8'h50);
        check("wr0_regs",   regs_a,   48'h000_B34_000_FFF);
        check("wr0_update", update_a, 4'b0001);

        // A0^FF^0F is 50, so a 5F checksum must be rejected
        send_a(8'hA0); send_a(8'hFF); send_a(8'h0F); send_a(8'h5F);
        check("sum5F_update", update_a, 4'b0000);
        idle(1);
        check("sum5F_errors", errors_a, 8'd2);

        // channel 7 does not exist
        send_a(8'hA7); send_a(8'h00); send_a(8'h00); send_a(8'hA7);
        check("ch7_update", update_a, 4'b0000);
        check("ch7_regs",   regs_a,   48'h000_B34_000_FFF);
        idle(1);
        check("ch7_errors", errors_a, 8'd3);

        // timeout after P0
        send_a(8'hA1); send_a(8'h55);
        idle(15);
        check("to_busy_before", busy_a, 1'b1);
        idle(1);
        check("to_busy_after", busy_a, 1'b0);
        idle(1);
        check("to_errors", errors_a, 8'd4);
        send_a(8'hA1); send_a(8'h55); send_a(8'h00); send_a(8'hF4);
        check("wr1_regs",   regs_a,   48'h000_B34_055_FFF);
        check("wr1_update", update_a, 4'b0010);

        // push on the timeout cycle wins; upper payload bits beyond WIDTH dropped
        send_a(8'hA1); send_a(8'h34);
        idle(15);
        send_a(8'hF2);
        check("race_busy", busy_a, 1'b1);
        send_a(8'h67);
        check("race_regs",   regs_a,   48'h000_B34_234_FFF);
        check("race_update", update_a, 4'b0010);
        idle(1);
        check("race_errors", errors_a, 8'd4);

        // inverted 8-bit instance, then stray bytes
        send_b(8'hA3); send_b(8'h0F); send_b(8'hAC);
        check("inv_regs",   regs_b,   32'hF05A5A5A);
        check("inv_update", update_b, 4'b1000);
        send_b(8'h12);
        check("stray12_busy", busy_b, 1'b0);
        send_b(8'hFF);
        check("strayFF_busy", busy_b, 1'b0);
        idle(2);
        check("stray_errors", errors_b, 8'd0);
        check("stray_regs",   regs_b,   32'hF05A5A5A);

        // reset between P0 and P1
        send_a(8'hA1); send_a(8'h11);
        resetn = 1'b0;
        #1;
        check("midrst_regs_a",   regs_a,   48'h0);
        check("midrst_regs_b",   regs_b,   32'h5A5A5A5A);
        check("midrst_busy_a",   busy_a,   1'b0);
        check("midrst_errors_a", errors_a, 8'd0);
        idle(1);
        resetn = 1'b1;
        send_a(8'h22); send_a(8'hB3);
        idle(2);
        check("postrst_regs_a",   regs_a,   48'h0);
        check("postrst_errors_a", errors_a, 8'd0);
        check("postrst_update_a", update_a, 4'b0000);

        // 300 rejected frames saturate the error counter
        for (int i = 0; i < 300; i++) begin
            send_b(8'hA0); send_b(8'h00); send_b(8'h00);
        end
        idle(2);
        check("sat_errors", errors_b, 8'd255);
        check("sat_regs",   regs_b,   32'h5A5A5A5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
